// File: rtl/mips_pkg.sv
// Shared opcodes, FSM encoding and lane constants for the data-memory access unit.
package mips_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned DATA_W = 32;

   localparam logic [OP_W-1:0] OP_NOP = 6'h00;
   localparam logic [OP_W-1:0] OP_LB  = 6'h20;
   localparam logic [OP_W-1:0] OP_LH  = 6'h21;
   localparam logic [OP_W-1:0] OP_LW  = 6'h23;
   localparam logic [OP_W-1:0] OP_LBU = 6'h24;
   localparam logic [OP_W-1:0] OP_LHU = 6'h25;
   localparam logic [OP_W-1:0] OP_SB  = 6'h28;
   localparam logic [OP_W-1:0] OP_SH  = 6'h29;
   localparam logic [OP_W-1:0] OP_SW  = 6'h2b;

   // Big-endian lane offsets within a word
   localparam logic [1:0] BYTE_OFF0 = 2'd0;
   localparam logic [1:0] BYTE_OFF1 = 2'd1;
   localparam logic [1:0] BYTE_OFF2 = 2'd2;
   localparam logic [1:0] BYTE_OFF3 = 2'd3;
   localparam logic [1:0] HALF_OFF0 = 2'd0;
   localparam logic [1:0] HALF_OFF2 = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RMW_READ,
      ST_RMW_WRITE,
      ST_RESP
   } state_e;

   function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LW, OP_SW:          mis = (off != 2'b00);
         OP_LH, OP_LHU, OP_SH:  mis = off[0];
         default:               mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extract/extend and sub-word store merge.
module lsu_align
   import mips_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [1:0]        offset,
   input  logic [DATA_W-1:0] word,
   input  logic [15:0]       storedata,
   output logic [DATA_W-1:0] loadword,
   output logic [DATA_W-1:0] mergedword
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        half_lo;

   always_comb begin
      half_lo  = ({offset[1], 1'b0} == HALF_OFF2);
      byte_sel = word[7:0];
      case (offset)
         BYTE_OFF0: byte_sel = word[31:24];
         BYTE_OFF1: byte_sel = word[23:16];
         BYTE_OFF2: byte_sel = word[15:8];
         BYTE_OFF3: byte_sel = word[7:0];
         default:   byte_sel = word[7:0];
      endcase
      half_sel = half_lo ? word[15:0] : word[31:16];
   end

   always_comb begin
      loadword = word;
      case (op)
         OP_LB:   loadword = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  loadword = {24'h000000, byte_sel};
         OP_LH:   loadword = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  loadword = {16'h0000, half_sel};
         default: loadword = word;
      endcase
   end

   // Replace only the addressed lane(s); everything else keeps the read word
   always_comb begin
      mergedword = word;
      case (op)
         OP_SB: begin
            case (offset)
               BYTE_OFF0: mergedword[31:24] = storedata[7:0];
               BYTE_OFF1: mergedword[23:16] = storedata[7:0];
               BYTE_OFF2: mergedword[15:8]  = storedata[7:0];
               default:   mergedword[7:0]   = storedata[7:0];
            endcase
         end
         OP_SH: begin
            if (half_lo) mergedword[15:0]  = storedata;
            else         mergedword[31:16] = storedata;
         end
         default: mergedword = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-only memory port; adds byte/half loads and RMW sub-word stores.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_W-1:0]       req_op,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_W-1:0]     req_storedata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_loaddata,
   output logic                  resp_misaligned,
   output logic [OP_W-1:0]       mem_op,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_W-1:0]     mem_writevalue,
   input  logic [DATA_W-1:0]     mem_readvalue
);

   state_e                state_q, state_d;
   logic [OP_W-1:0]       op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     sdata_q, sdata_d;
   logic [DATA_W-1:0]     rdword_q, rdword_d;
   logic [DATA_W-1:0]     resp_data_q, resp_data_d;
   logic                  resp_mis_q, resp_mis_d;
   logic                  resp_valid_q;

   logic [DATA_W-1:0]     align_word;
   logic [DATA_W-1:0]     loadword;
   logic [DATA_W-1:0]     mergedword;

   // Loads extract from live read data; RMW merges into the word captured in RMW_READ
   assign align_word = (state_q == ST_RMW_WRITE) ? rdword_q : mem_readvalue;

   lsu_align u_lsu_align (
      .op         (op_q),
      .offset     (addr_q[1:0]),
      .word       (align_word),
      .storedata  (sdata_q[15:0]),
      .loadword   (loadword),
      .mergedword (mergedword)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_NOP;
         addr_q       <= '0;
         sdata_q      <= '0;
         rdword_q     <= '0;
         resp_data_q  <= '0;
         resp_mis_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         rdword_q     <= rdword_d;
         resp_data_q  <= resp_data_d;
         resp_mis_q   <= resp_mis_d;
         resp_valid_q <= (state_d == ST_RESP);
      end
   end

   // Next-state and response capture; response regs only change on entry to RESP
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      sdata_d     = sdata_q;
      rdword_d    = rdword_q;
      resp_data_d = resp_data_q;
      resp_mis_d  = resp_mis_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_address;
               sdata_d = req_storedata;
               if (CHECK_ALIGN && is_misaligned(req_op, req_address[1:0])) begin
                  state_d     = ST_RESP;
                  resp_data_d = '0;
                  resp_mis_d  = 1'b1;
               end else begin
                  case (req_op)
                     OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW: state_d = ST_ACCESS;
                     OP_SB, OP_SH:                               state_d = ST_RMW_READ;
                     default: begin
                        state_d     = ST_RESP;
                        resp_data_d = '0;
                        resp_mis_d  = 1'b0;
                     end
                  endcase
               end
            end
         end
         ST_ACCESS: begin
            state_d     = ST_RESP;
            resp_data_d = (op_q == OP_SW) ? '0 : loadword;
            resp_mis_d  = 1'b0;
         end
         ST_RMW_READ: begin
            rdword_d = mem_readvalue;
            state_d  = ST_RMW_WRITE;
         end
         ST_RMW_WRITE: begin
            state_d     = ST_RESP;
            resp_data_d = '0;
            resp_mis_d  = 1'b0;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory port decode; reset suppresses any access so an in-flight store never lands
   always_comb begin
      mem_op = OP_NOP;
      case (state_q)
         ST_ACCESS:    mem_op = (op_q == OP_SW) ? OP_SW : OP_LW;
         ST_RMW_READ:  mem_op = OP_LW;
         ST_RMW_WRITE: mem_op = OP_SW;
         default:      mem_op = OP_NOP;
      endcase
      if (reset) mem_op = OP_NOP;
   end

   assign mem_address     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_writevalue  = (state_q == ST_RMW_WRITE) ? mergedword : sdata_q;
   assign req_ready       = (state_q == ST_IDLE);
   assign resp_valid      = resp_valid_q;
   assign resp_loaddata   = resp_data_q;
   assign resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide behavioural data memory.
module tb_mem_access_unit;
   import mips_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_op = 6'h00;
   logic [31:0] req_address = 32'h0;
   logic [31:0] req_storedata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_loaddata;
   logic        resp_misaligned;
   logic [5:0]  mem_op;
   logic [31:0] mem_address;
   logic [31:0] mem_writevalue;
   logic [31:0] mem_readvalue;

   int tests_run = 0;
   int failed    = 0;

   logic [31:0] mem [0:63];
   logic        tb_we = 1'b0;
   logic [5:0]  tb_widx = 6'd0;
   logic [31:0] tb_wdata = 32'h0;
   int          lw_cnt = 0;
   int          sw_cnt = 0;
   logic [31:0] last_wr_addr = 32'h0;

   mem_access_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_address     (req_address),
      .req_storedata   (req_storedata),
      .resp_valid      (resp_valid),
      .resp_loaddata   (resp_loaddata),
      .resp_misaligned (resp_misaligned),
      .mem_op          (mem_op),
      .mem_address     (mem_address),
      .mem_writevalue  (mem_writevalue),
      .mem_readvalue   (mem_readvalue)
   );

   always #5 clock = ~clock;

   assign mem_readvalue = mem[mem_address[7:2]];

   always @(posedge clock) begin
      if (tb_we) mem[tb_widx] <= tb_wdata;
      else if (mem_op == 6'h2b) mem[mem_address[7:2]] <= mem_writevalue;
      if (mem_op == 6'h2b) begin
         sw_cnt       <= sw_cnt + 1;
         last_wr_addr <= mem_address;
      end
      if (mem_op == 6'h23) lw_cnt <= lw_cnt + 1;
   end

   task automatic poke(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clock);
      tb_we = 1'b1; tb_widx = idx; tb_wdata = data;
      @(negedge clock);
      tb_we = 1'b0;
   endtask

   // Issue one request from a negedge; returns at the negedge where resp_valid is seen
   task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        output int lat, output int waits, output logic busy_rdy);
      lat = 0; waits = 0; busy_rdy = 1'b0;
      req_valid = 1'b1; req_op = op; req_address = addr; req_storedata = sd;
      while (!req_ready && waits < 10) begin
         @(negedge clock);
         waits++;
      end
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_op = 6'h00;
      for (int c = 1; c <= 10; c++) begin
         if (resp_valid) begin
            lat = c;
            break;
         end
         if (req_ready) busy_rdy = 1'b1;
         @(negedge clock);
      end
      if (lat == 0) begin
         tests_run++; failed++;
         $display("FAIL issue_timeout op=%h addr=%h: no resp_valid within 10 cycles", op, addr);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      @(negedge clock);
      tests_run++;
      if (mem_op !== 6'h00) begin failed++; $display("FAIL reset_memop_in_reset got=%h exp=00", mem_op); end
      reset = 1'b0;
      @(negedge clock);
      tests_run++;
      if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      tests_run++;
      if (resp_valid !== 1'b0 || resp_misaligned !== 1'b0) begin
         failed++; $display("FAIL reset_resp got valid=%b mis=%b exp 0 0", resp_valid, resp_misaligned);
      end
      tests_run++;
      if (resp_loaddata !== 32'h0) begin failed++; $display("FAIL reset_loaddata got=%h exp=0", resp_loaddata); end
      tests_run++;
      if (mem_op !== 6'h00) begin failed++; $display("FAIL reset_memop got=%h exp=00", mem_op); end
   endtask

   task automatic test_loads();
      logic [5:0]  ops  [7] = '{OP_LB, OP_LBU, OP_LHU, OP_LH, OP_LW, OP_LB, OP_LBU};
      logic [31:0] adrs [7] = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10, 32'h11};
      logic [31:0] exps [7] = '{32'hFFFFFF99, 32'h000000BB, 32'h0000AABB, 32'hFFFF8899,
                                32'h8899AABB, 32'hFFFFFF88, 32'h00000099};
      int lat, waits, lw0, sw0;
      logic busy;
      poke(6'd4, 32'h8899AABB);
      for (int i = 0; i < 7; i++) begin
         lw0 = lw_cnt; sw0 = sw_cnt;
         issue(ops[i], adrs[i], 32'h0, lat, waits, busy);
         tests_run++;
         if (resp_loaddata !== exps[i] || resp_misaligned !== 1'b0) begin
            failed++;
            $display("FAIL load_data[%0d] op=%h got=%h mis=%b exp=%h mis=0", i, ops[i], resp_loaddata, resp_misaligned, exps[i]);
         end
         tests_run++;
         if (lat != 2 || busy) begin
            failed++; $display("FAIL load_latency[%0d] got=%0d busy_ready=%b exp=2 busy_ready=0", i, lat, busy);
         end
         tests_run++;
         if (lw_cnt - lw0 != 1 || sw_cnt != sw0) begin
            failed++; $display("FAIL load_accesses[%0d] got lw=%0d sw=%0d exp lw=1 sw=0", i, lw_cnt - lw0, sw_cnt - sw0);
         end
      end
   endtask

   task automatic test_rmw_store();
      int lat, waits, lw0, sw0;
      logic busy;
      lw0 = lw_cnt; sw0 = sw_cnt;
      issue(OP_SB, 32'h12, 32'h00000055, lat, waits, busy);
      @(negedge clock);
      tests_run++;
      if (mem[4] !== 32'h889955BB) begin failed++; $display("FAIL sb_word got=%h exp=889955bb", mem[4]); end
      tests_run++;
      if (lat != 3) begin failed++; $display("FAIL sb_latency got=%0d exp=3", lat); end
      tests_run++;
      if (lw_cnt - lw0 != 1 || sw_cnt - sw0 != 1 || last_wr_addr !== 32'h10) begin
         failed++;
         $display("FAIL sb_accesses got lw=%0d sw=%0d addr=%h exp 1 1 10", lw_cnt - lw0, sw_cnt - sw0, last_wr_addr);
      end
      tests_run++;
      if (resp_loaddata !== 32'h0) begin failed++; $display("FAIL sb_resp_data got=%h exp=0", resp_loaddata); end
      poke(6'd5, 32'h11223344);
      issue(OP_SH, 32'h16, 32'hFFFF1234, lat, waits, busy);
      @(negedge clock);
      tests_run++;
      if (mem[5] !== 32'h11221234 || lat != 3) begin
         failed++; $display("FAIL sh_lo got=%h lat=%0d exp=11221234 lat=3", mem[5], lat);
      end
      issue(OP_SB, 32'h14, 32'hABCDEF77, lat, waits, busy);
      @(negedge clock);
      tests_run++;
      if (mem[5] !== 32'h77221234) begin failed++; $display("FAIL sb_lane0 got=%h exp=77221234", mem[5]); end
   endtask

   task automatic test_misaligned();
      logic [5:0]  ops  [4] = '{OP_LW, OP_SH, OP_SW, 6'h0F};
      logic [31:0] adrs [4] = '{32'h06, 32'h13, 32'h22, 32'h10};
      logic        emis [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      int lat, waits, lw0, sw0, badop;
      logic busy;
      logic [31:0] m4;
      for (int i = 0; i < 4; i++) begin
         m4 = mem[4];
         lw0 = lw_cnt; sw0 = sw_cnt;
         issue(ops[i], adrs[i], 32'h12345678, lat, waits, busy);
         tests_run++;
         if (lat != 1 || resp_misaligned !== emis[i] || resp_loaddata !== 32'h0) begin
            failed++;
            $display("FAIL nonaccess[%0d] op=%h got lat=%0d mis=%b data=%h exp lat=1 mis=%b data=0",
                     i, ops[i], lat, resp_misaligned, resp_loaddata, emis[i]);
         end
         tests_run++;
         badop = 0;
         if (lw_cnt != lw0 || sw_cnt != sw0 || mem[4] !== m4) badop = 1;
         if (badop != 0) begin
            failed++; $display("FAIL nonaccess_mem[%0d] got lw=%0d sw=%0d exp no access", i, lw_cnt - lw0, sw_cnt - sw0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, waits;
      logic busy;
      issue(OP_SW, 32'h20, 32'hDEADBEEF, lat, waits, busy);
      tests_run++;
      if (lat != 2 || busy) begin failed++; $display("FAIL b2b_sw got lat=%0d busy_ready=%b exp 2 0", lat, busy); end
      issue(OP_LW, 32'h20, 32'h0, lat, waits, busy);
      tests_run++;
      if (waits != 1) begin failed++; $display("FAIL b2b_accept_wait got=%0d exp=1", waits); end
      tests_run++;
      if (resp_loaddata !== 32'hDEADBEEF || lat != 2 || busy) begin
         failed++; $display("FAIL b2b_lw got=%h lat=%0d busy_ready=%b exp=deadbeef 2 0", resp_loaddata, lat, busy);
      end
      @(negedge clock);
      tests_run++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failed++; $display("FAIL resp_one_cycle got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
      end
      @(negedge clock);
      tests_run++;
      if (resp_loaddata !== 32'hDEADBEEF) begin failed++; $display("FAIL resp_hold got=%h exp=deadbeef", resp_loaddata); end
   endtask

   task automatic test_reset_abort();
      int sw0, lat, waits;
      logic seen;
      logic busy;
      poke(6'd6, 32'hCAFEF00D);
      sw0 = sw_cnt;
      req_valid = 1'b1; req_op = OP_SH; req_address = 32'h18; req_storedata = 32'h00007777;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_op = 6'h00;
      tests_run++;
      if (mem_op !== 6'h23) begin failed++; $display("FAIL abort_rmw_read got=%h exp=23", mem_op); end
      @(negedge clock);
      tests_run++;
      if (mem_op !== 6'h2b || mem_writevalue !== 32'h7777F00D) begin
         failed++; $display("FAIL abort_rmw_write got op=%h wv=%h exp 2b 7777f00d", mem_op, mem_writevalue);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (mem_op !== 6'h00) begin failed++; $display("FAIL abort_memop_forced got=%h exp=00", mem_op); end
      @(negedge clock);
      reset = 1'b0;
      tests_run++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failed++; $display("FAIL abort_idle got ready=%b valid=%b exp 1 0", req_ready, resp_valid);
      end
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clock);
      end
      tests_run++;
      if (seen || mem[6] !== 32'hCAFEF00D || sw_cnt != sw0) begin
         failed++; $display("FAIL abort_no_commit got resp_seen=%b word=%h sw=%0d exp 0 cafef00d 0", seen, mem[6], sw_cnt - sw0);
      end
      issue(OP_LW, 32'h18, 32'h0, lat, waits, busy);
      tests_run++;
      if (resp_loaddata !== 32'hCAFEF00D || lat != 2) begin
         failed++; $display("FAIL after_abort_lw got=%h lat=%0d exp=cafef00d 2", resp_loaddata, lat);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_rmw_store();
      test_misaligned();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
